// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game controller: raises one of four moles at pseudo-random holes,
// scores laser hits in BCD and runs a fixed-length game clocked by a slow tick.
module mole_game_ctrl #(
  parameter int unsigned TICK_DIV   = 4194304,
  parameter int unsigned MOLE_TICKS = 12,
  parameter int unsigned HIT_TICKS  = 2,
  parameter int unsigned GAME_TICKS = 600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       shooting,
  input  logic [3:0] hit_sensor,
  output logic [3:0] mole_en,
  output logic       gun_enable,
  output logic [7:0] score,
  output logic [9:0] time_left,
  output logic       game_over
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned MoleW = (MOLE_TICKS > 0) ? $clog2(MOLE_TICKS + 1) : 1;
  localparam int unsigned HitW  = (HIT_TICKS > 0) ? $clog2(HIT_TICKS + 1) : 1;
  localparam int unsigned TimeW = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPAWN,
    S_UP,
    S_HIT,
    S_OVER
  } state_e;

  state_e             state_q, state_d;
  logic [TickW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic               start_q;
  logic [1:0]         hole_q, hole_d;
  logic [MoleW-1:0]   mole_tmr_q, mole_tmr_d;
  logic [HitW-1:0]    hit_tmr_q, hit_tmr_d;
  logic [7:0]         score_q, score_d;
  logic [TimeW-1:0]   time_q, time_d;
  logic [3:0]         mole_en_q, mole_en_d;
  logic               gun_q, gun_d;
  logic               over_q, over_d;

  logic               tick_c;
  logic               start_edge_c;
  logic [1:0]         spawn_hole_c;
  logic               active_c;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99) return v;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign tick_c       = (tick_cnt_q == TickW'(TICK_DIV - 1));
  assign tick_cnt_d   = tick_c ? '0 : tick_cnt_q + TickW'(1);
  assign lfsr_d       = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign start_edge_c = start & ~start_q;
  assign spawn_hole_c = (lfsr_q[1:0] == hole_q) ? lfsr_q[1:0] + 2'd1 : lfsr_q[1:0];
  assign active_c     = (state_q == S_SPAWN) || (state_q == S_UP) || (state_q == S_HIT);

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    hole_d     = hole_q;
    mole_tmr_d = mole_tmr_q;
    hit_tmr_d  = hit_tmr_q;
    score_d    = score_q;
    time_d     = time_q;
    mole_en_d  = mole_en_q;

    case (state_q)
      S_IDLE, S_OVER: begin
        mole_en_d = '0;
        if (start_edge_c) begin
          score_d = 8'h00;
          time_d  = TimeW'(GAME_TICKS);
          state_d = S_SPAWN;
        end
      end
      S_SPAWN: begin
        hole_d     = spawn_hole_c;
        mole_en_d  = 4'b0001 << spawn_hole_c;
        mole_tmr_d = MoleW'(MOLE_TICKS);
        state_d    = S_UP;
      end
      S_UP: begin
        if (shooting && hit_sensor[hole_q]) begin
          score_d   = bcd_inc(score_q);
          mole_en_d = '0;
          hit_tmr_d = HitW'(HIT_TICKS);
          state_d   = S_HIT;
        end else if (tick_c) begin
          if (mole_tmr_q <= MoleW'(1)) begin
            mole_tmr_d = '0;
            mole_en_d  = '0;
            state_d    = S_SPAWN;
          end else begin
            mole_tmr_d = mole_tmr_q - MoleW'(1);
          end
        end
      end
      S_HIT: begin
        if (tick_c) begin
          if (hit_tmr_q <= HitW'(1)) begin
            hit_tmr_d = '0;
            state_d   = S_SPAWN;
          end else begin
            hit_tmr_d = hit_tmr_q - HitW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Game clock overrides mole flow; a hit in the same cycle is still scored above
    if (active_c && tick_c) begin
      if (time_q <= TimeW'(1)) begin
        time_d    = '0;
        mole_en_d = '0;
        state_d   = S_OVER;
      end else begin
        time_d = time_q - TimeW'(1);
      end
    end

    gun_d  = (state_d == S_SPAWN) || (state_d == S_UP) || (state_d == S_HIT);
    over_d = (state_d == S_OVER);
  end

  // start_q resets high so a switch already on at reset release is not taken as an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      lfsr_q     <= 8'hA5;
      start_q    <= 1'b1;
      hole_q     <= 2'd3;
      mole_tmr_q <= '0;
      hit_tmr_q  <= '0;
      score_q    <= 8'h00;
      time_q     <= '0;
      mole_en_q  <= '0;
      gun_q      <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      lfsr_q     <= lfsr_d;
      start_q    <= start;
      hole_q     <= hole_d;
      mole_tmr_q <= mole_tmr_d;
      hit_tmr_q  <= hit_tmr_d;
      score_q    <= score_d;
      time_q     <= time_d;
      mole_en_q  <= mole_en_d;
      gun_q      <= gun_d;
      over_q     <= over_d;
    end
  end

  assign mole_en    = mole_en_q;
  assign gun_enable = gun_q;
  assign score      = score_q;
  assign time_left  = time_q;
  assign game_over  = over_q;

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Bench for mole_game_ctrl: a short game instance plus a long game instance that
// fires constantly to reach score saturation, both checked against a game model.
module tb_mole_game_ctrl;

  localparam int TD  = 4;
  localparam int MT  = 3;
  localparam int HT  = 2;
  localparam int GT0 = 20;
  localparam int GT1 = 600;

  localparam int PH_IDLE  = 0;
  localparam int PH_SPAWN = 1;
  localparam int PH_UP    = 2;
  localparam int PH_HIT   = 3;
  localparam int PH_OVER  = 4;

  logic       clk, rst, start;
  logic       sh0, sh1;
  logic [3:0] hs0, hs1;
  logic [3:0] m0, m1;
  logic       g0, g1, o0, o1;
  logic [7:0] s0, s1;
  logic [9:0] t0, t1;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  // game model state, one slot per instance
  int         m_phase[2];
  int         m_tc[2];
  int         m_up[2];
  int         m_blank[2];
  int         m_score[2];
  int         m_time[2];
  int         m_prev[2];
  logic [7:0] m_lfsr[2];
  logic       m_sp[2];
  logic [3:0] m_mole[2];

  logic [7:0] sat_prev = 8'h00;
  bit         seen_carry = 0;

  mole_game_ctrl #(.TICK_DIV(TD), .MOLE_TICKS(MT), .HIT_TICKS(HT), .GAME_TICKS(GT0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .shooting(sh0), .hit_sensor(hs0),
    .mole_en(m0), .gun_enable(g0), .score(s0), .time_left(t0), .game_over(o0)
  );

  mole_game_ctrl #(.TICK_DIV(TD), .MOLE_TICKS(MT), .HIT_TICKS(HT), .GAME_TICKS(GT1)) u_sat (
    .clk(clk), .rst(rst), .start(start), .shooting(sh1), .hit_sensor(hs1),
    .mole_en(m1), .gun_enable(g1), .score(s1), .time_left(t1), .game_over(o1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int game_len(input int i);
    return (i == 0) ? GT0 : GT1;
  endfunction

  task automatic model_reset(input int i);
    m_phase[i] = PH_IDLE;
    m_tc[i]    = 0;
    m_up[i]    = 0;
    m_blank[i] = 0;
    m_score[i] = 0;
    m_time[i]  = 0;
    m_prev[i]  = 3;
    m_lfsr[i]  = 8'hA5;
    m_sp[i]    = 1'b1;
    m_mole[i]  = 4'h0;
  endtask

  task automatic model_step(input int i, input logic st, input logic sh, input logic [3:0] hs);
    int         ph0;
    int         h;
    bit         tick;
    bit         edge_s;
    logic [7:0] lf;
    ph0    = m_phase[i];
    tick   = (m_tc[i] == TD - 1);
    edge_s = st && !m_sp[i];
    lf     = m_lfsr[i];
    m_tc[i]   = tick ? 0 : m_tc[i] + 1;
    m_sp[i]   = st;
    m_lfsr[i] = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
    case (ph0)
      PH_IDLE, PH_OVER: begin
        if (edge_s) begin
          m_score[i] = 0;
          m_time[i]  = game_len(i);
          m_phase[i] = PH_SPAWN;
        end
      end
      PH_SPAWN: begin
        h = int'(lf[1:0]);
        if (h == m_prev[i]) h = (h + 1) % 4;
        m_prev[i]  = h;
        m_mole[i]  = 4'(1 << h);
        m_up[i]    = MT;
        m_phase[i] = PH_UP;
      end
      PH_UP: begin
        if (sh && hs[m_prev[i]]) begin
          if (m_score[i] < 99) m_score[i]++;
          m_mole[i]  = 4'h0;
          m_blank[i] = HT;
          m_phase[i] = PH_HIT;
        end else if (tick) begin
          m_up[i]--;
          if (m_up[i] == 0) begin
            m_mole[i]  = 4'h0;
            m_phase[i] = PH_SPAWN;
          end
        end
      end
      PH_HIT: begin
        if (tick) begin
          m_blank[i]--;
          if (m_blank[i] == 0) m_phase[i] = PH_SPAWN;
        end
      end
      default: ;
    endcase
    if ((ph0 == PH_SPAWN || ph0 == PH_UP || ph0 == PH_HIT) && tick) begin
      m_time[i]--;
      if (m_time[i] == 0) begin
        m_phase[i] = PH_OVER;
        m_mole[i]  = 4'h0;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, start, sh0, hs0);
      model_step(1, start, sh1, hs1);
    end
  end

  task automatic cmp_inst(input int i, input logic [3:0] m, input logic g, input logic [7:0] s,
                          input logic [9:0] t, input logic o);
    bit exp_gun;
    exp_gun = (m_phase[i] == PH_SPAWN) || (m_phase[i] == PH_UP) || (m_phase[i] == PH_HIT);
    chk($sformatf("u%0d_mole_en", i), 32'(m), 32'(m_mole[i]));
    chk($sformatf("u%0d_gun_enable", i), 32'(g), 32'(exp_gun));
    chk($sformatf("u%0d_score", i), 32'(s), 32'((m_score[i] / 10) * 16 + (m_score[i] % 10)));
    chk($sformatf("u%0d_time_left", i), 32'(t), 32'(m_time[i]));
    chk($sformatf("u%0d_game_over", i), 32'(o), 32'(m_phase[i] == PH_OVER));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst(0, m0, g0, s0, t0, o0);
      cmp_inst(1, m1, g1, s1, t1, o1);
    end
  end

  // the long game must pass through 09 -> 10 on its way to 99
  always @(negedge clk) begin
    if (chk_en) begin
      if (sat_prev == 8'h09 && s1 != 8'h09) begin
        chk("bcd_carry_09_10", 32'(s1), 32'h10);
        seen_carry <= 1'b1;
      end
      sat_prev <= s1;
    end
  end

  task automatic wait_raise(input string nm, input logic [3:0] prev_h, output logic [3:0] got);
    int n;
    n = 0;
    while (m0 == 4'h0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_timeout"}, 32'(n >= 60), 32'h0);
    chk({nm, "_onehot"}, 32'($countones(m0)), 32'h1);
    chk(nm, 32'(m0 & prev_h), 32'h0);
    got = m0;
  endtask

  initial begin
    logic [3:0] hole;
    logic [3:0] nxt;
    int         n;
    bit         fired;
    clk = 0; rst = 0; start = 0;
    sh0 = 0; hs0 = 4'h0; sh1 = 1; hs1 = 4'hF;
    #1 rst = 1;
    #1 chk_en = 1;
    #1;
    chk("rst_mole_en", 32'(m0), 32'h0);
    chk("rst_gun", 32'(g0), 32'h0);
    chk("rst_score", 32'(s0), 32'h0);
    chk("rst_time", 32'(t0), 32'h0);
    chk("rst_over", 32'(o0), 32'h0);
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);

    // start a game: SPAWN one cycle after the edge, mole up the cycle after
    start = 1;
    @(negedge clk);
    chk("start_time_left", 32'(t0), 32'd20);
    chk("start_gun", 32'(g0), 32'h1);
    chk("start_mole_en", 32'(m0), 32'h0);
    @(negedge clk);
    chk("spawn_onehot", 32'($countones(m0)), 32'h1);
    hole = m_mole[0];
    sh0 = 1; hs0 = m_mole[0];
    @(negedge clk);
    chk("hit_score", 32'(s0), 32'h01);
    chk("hit_mole_clear", 32'(m0), 32'h0);
    sh0 = 0; hs0 = 4'h0; start = 0;
    wait_raise("hit_next_hole", hole, nxt);

    // miss: mole drops after three ticks, score unchanged, mid-game start ignored
    hole = nxt;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (n == 2) start = 1;
      if (n == 3) start = 0;
      if (m0 == 4'h0) break;
    end
    chk("miss_duration", 32'(n >= 9 && n <= 12), 32'h1);
    chk("miss_score", 32'(s0), 32'h01);
    wait_raise("miss_next_hole", hole, nxt);

    // run out the clock, shooting only in the cycle of the final tick
    n = 0;
    fired = 0;
    while (o0 == 1'b0 && n < 200) begin
      if (m_phase[0] == PH_UP && m_time[0] == 1 && m_tc[0] == TD - 1) begin
        sh0 = 1; hs0 = m_mole[0]; fired = 1;
      end else begin
        sh0 = 0; hs0 = 4'h0;
      end
      @(negedge clk);
      n++;
    end
    sh0 = 0; hs0 = 4'h0;
    chk("final_shot_armed", 32'(fired), 32'h1);
    chk("over_flag", 32'(o0), 32'h1);
    chk("over_gun", 32'(g0), 32'h0);
    chk("over_mole", 32'(m0), 32'h0);
    chk("over_time", 32'(t0), 32'h0);
    chk("over_final_hit_scored", 32'(s0), 32'h02);

    // restart from OVER
    start = 1;
    @(negedge clk);
    chk("restart_score", 32'(s0), 32'h00);
    chk("restart_time", 32'(t0), 32'd20);
    chk("restart_over", 32'(o0), 32'h0);
    chk("restart_gun", 32'(g0), 32'h1);
    start = 0;

    // long game saturates at 99
    n = 0;
    while (s1 != 8'h99 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("sat_reached", 32'(s1), 32'h99);
    chk("carry_observed", 32'(seen_carry), 32'h1);
    repeat (60) @(negedge clk);
    chk("sat_hold", 32'(s1), 32'h99);

    // async reset while a mole is up, with start held high through release
    start = 1;
    n = 0;
    while (m_phase[0] != PH_UP && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reach_up_timeout", 32'(n >= 20), 32'h0);
    #2 rst = 1;
    #1;
    chk("arst_mole_en", 32'(m0), 32'h0);
    chk("arst_gun", 32'(g0), 32'h0);
    chk("arst_score", 32'(s0), 32'h0);
    chk("arst_time", 32'(t0), 32'h0);
    chk("arst_over", 32'(o0), 32'h0);
    chk("arst_sat_score", 32'(s1), 32'h0);
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (10) @(negedge clk);
    chk("held_start_gun", 32'(g0), 32'h0);
    chk("held_start_time", 32'(t0), 32'h0);
    chk("held_start_sat_gun", 32'(g1), 32'h0);
    start = 0;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mole_game_ctrl.md
MOLE_GAME_CTRL -- requirements
Module: mole_game_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 4194304: number of clk cycles per game tick.
REQ-002 SHALL have parameter MOLE_TICKS, default 12: number of ticks a mole stays up.
REQ-003 SHALL have parameter HIT_TICKS, default 2: number of ticks the board stays blank after a hit.
REQ-004 SHALL have parameter GAME_TICKS, default 600: length of one game in ticks.
REQ-005 SHALL have port clk, input, 1 bit: clock.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port start, input, 1 bit: level from a switch; a rising edge requests a new game.
REQ-008 SHALL have port shooting, input, 1 bit: laser gun is firing.
REQ-009 SHALL have port hit_sensor, input, 4 bits: per-hole light sensor, 1 = laser detected.
REQ-010 SHALL have port mole_en, output, 4 bits: one-hot raised-mole select.
REQ-011 SHALL have port gun_enable, output, 1 bit: permits the gun to fire.
REQ-012 SHALL have port score, output, 8 bits: two BCD digits, tens in [7:4].
REQ-013 SHALL have port time_left, output, 10 bits: remaining game ticks.
REQ-014 SHALL have port game_over, output, 1 bit: game has finished.

Function
REQ-015 Tick counter SHALL count 0..TICK_DIV-1 and assert an internal 1-cycle tick on wrap; it runs in all states.
REQ-016 An 8-bit LFSR SHALL use polynomial x^8+x^6+x^5+x^4+1, be seeded 8'hA5, and advance every clk.
REQ-017 start edge SHALL be detected using a registered copy of start; held-high start SHALL NOT retrigger.
REQ-018 FSM states SHALL be IDLE, SPAWN, UP, HIT, OVER; all outputs SHALL be registered.
REQ-019 IDLE: mole_en=0, gun_enable=0, game_over=0; on start edge, score SHALL clear to 8'h00, time_left SHALL load GAME_TICKS, and the FSM SHALL go to SPAWN.
REQ-020 SPAWN (exactly 1 cycle): hole = lfsr[1:0]; if hole equals the previous hole, hole SHALL become (hole+1) mod 4; mole_en SHALL be one-hot(hole); mole timer SHALL load MOLE_TICKS; the FSM SHALL go to UP.
REQ-021 UP: when shooting && hit_sensor[hole] in the same cycle, score SHALL increment in BCD, mole_en SHALL clear, hit timer SHALL load HIT_TICKS, and the FSM SHALL go to HIT.
REQ-022 UP: hit_sensor bits of non-raised holes, and shooting without a sensor hit, SHALL be ignored.
REQ-023 UP: the mole timer SHALL decrement on tick; on reaching 0 (miss), mole_en SHALL clear, score SHALL be unchanged, and the FSM SHALL go to SPAWN.
REQ-024 HIT: the hit timer SHALL decrement on tick; at 0 the FSM SHALL go to SPAWN.
REQ-025 BCD increment: units 9 -> 0 with carry to tens; score SHALL saturate at 8'h99.
REQ-026 In SPAWN/UP/HIT, gun_enable SHALL be 1 and time_left SHALL decrement on tick; when time_left reaches 0, the FSM SHALL go to OVER.
REQ-027 When a valid hit and the final time_left decrement occur in the same cycle, the hit SHALL be scored and the FSM SHALL enter OVER.
REQ-028 OVER: game_over=1, gun_enable=0, mole_en=0, score held; a start edge SHALL clear score, load time_left, clear game_over, and go to SPAWN.
REQ-029 A start edge during SPAWN/UP/HIT SHALL be ignored.
REQ-030 The previous-hole register SHALL reset to 2'd3.

Reset
REQ-031 On rst: state=IDLE, mole_en=0, gun_enable=0, score=8'h00, time_left=0, game_over=0, LFSR=8'hA5, all counters 0; this SHALL apply mid-game and take effect immediately, without waiting for clk.

Verification (TICK_DIV=4, MOLE_TICKS=3, HIT_TICKS=2, GAME_TICKS=20)
REQ-032 Reset then start pulse -> SPAWN 1 cycle after the edge; mole_en one-hot; gun_enable=1; time_left=20.
REQ-033 shooting=1 with hit_sensor matching mole_en -> score 8'h01, mole_en=0 for 2 ticks, then a different hole raised.
REQ-034 No shot -> mole_en clears after 3 ticks; score unchanged; next hole differs from the previous one.
REQ-035 Score preloaded via 9 and 99 hits -> 8'h09 -> 8'h10; 8'h99 stays 8'h99.
REQ-036 Run 20 ticks -> game_over=1, gun_enable=0, mole_en=0; a hit in the final cycle is counted; new start edge -> score 0, time_left=20.
REQ-037 rst asserted while in UP -> all outputs at reset values without a clk edge; held-high start after rst release does not start a game.
